// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Multi-channel pushbutton conditioner for the calculator front panel.
//   For each channel the raw button is synchronised and debounced with a
//   consecutive-sample integrator on a shared slow tick. The result is a
//   clean level plus one-cycle press, release and auto-repeat pulses.
//
// Parameters
//   CHANNELS      number of independent buttons
//   TICK_DIV      clk cycles per sample tick (>=1, 1 = every cycle)
//   STABLE_TICKS  consecutive disagreeing ticks needed to flip the level (>=1)
//   REPEAT_EN     nonzero enables auto-repeat, 0 holds btn_repeat at 0
//   REPEAT_DELAY  ticks from press to the first repeat (>=1)
//   REPEAT_RATE   ticks between subsequent repeats (>=1)
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   btn_in       in   [CHANNELS] raw asynchronous buttons, active-high
//   btn_level    out  [CHANNELS] debounced level
//   btn_press    out  [CHANNELS] one-cycle pulse on debounced 0->1
//   btn_release  out  [CHANNELS] one-cycle pulse on debounced 1->0
//   btn_repeat   out  [CHANNELS] one-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned CHANNELS     = 5,
  parameter int unsigned TICK_DIV     = 250000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 200,
  parameter int unsigned REPEAT_RATE  = 40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HCNT_W   = $clog2(HOLD_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [HCNT_W-1:0] DELAY_V   = HCNT_W'(REPEAT_DELAY);
  localparam logic [HCNT_W-1:0] RATE_V    = HCNT_W'(REPEAT_RATE);
  localparam logic [HCNT_W-1:0] HCNT_SAT  = {HCNT_W{1'b1}};
  localparam bit                REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } state_t;

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_c;
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  // Shared sample tick: one-cycle strobe on the last count, wrapping on the same edge.
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic              level;
    logic              level_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    state_t            state;
    state_t            state_nxt;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_nxt;
    logic [HCNT_W-1:0] hcnt_inc;
    logic              press_nxt;
    logic              release_nxt;
    logic              repeat_nxt;
    logic              press_q;
    logic              release_q;
    logic              repeat_q;

    // Integrator: the level flips only after STABLE_TICKS consecutive
    // disagreeing ticks; any agreeing tick restarts the count.
    always_comb begin
      level_nxt = level;
      cnt_nxt   = cnt;
      if (tick_c) begin
        if (sync_q2[g] == level) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = sync_q2[g];
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end

    // Press/hold/repeat FSM. It looks at the level being written on this
    // tick so that the pulses land on the same edge as the level change.
    always_comb begin
      state_nxt   = state;
      hcnt_nxt    = hcnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      repeat_nxt  = 1'b0;
      hcnt_inc    = hcnt + HCNT_W'(1);
      if (tick_c) begin
        case (state)
          ST_RELEASED: begin
            if (level_nxt) begin
              state_nxt = ST_HELD;
              hcnt_nxt  = '0;
              press_nxt = 1'b1;
            end
          end
          ST_HELD: begin
            if (!level_nxt) begin
              state_nxt   = ST_RELEASED;
              release_nxt = 1'b1;
            end else if (REP_ON && (hcnt_inc == DELAY_V)) begin
              state_nxt  = ST_REPEAT;
              hcnt_nxt   = '0;
              repeat_nxt = 1'b1;
            end else if (hcnt != HCNT_SAT) begin
              // Saturate so a long hold without repeat never wraps.
              hcnt_nxt = hcnt_inc;
            end
          end
          ST_REPEAT: begin
            if (!level_nxt) begin
              state_nxt   = ST_RELEASED;
              release_nxt = 1'b1;
            end else if (hcnt_inc == RATE_V) begin
              hcnt_nxt   = '0;
              repeat_nxt = 1'b1;
            end else begin
              hcnt_nxt = hcnt_inc;
            end
          end
          default: begin
            state_nxt = ST_RELEASED;
            hcnt_nxt  = '0;
          end
        endcase
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
      if (reset) begin
        level     <= 1'b0;
        cnt       <= '0;
        state     <= ST_RELEASED;
        hcnt      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        level     <= level_nxt;
        cnt       <= cnt_nxt;
        state     <= state_nxt;
        hcnt      <= hcnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        repeat_q  <= repeat_nxt;
      end
    end

    assign btn_level[g]   = level;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_repeat[g]  = repeat_q;
  end

endmodule
